// File: rtl/seg_scroll_engine.sv
// seg_scroll_engine: nibble-ring message scroller with load handshake, run/hold/step and wrap/frame strobes.
// Defining SEG_SCROLL_BOUNCE_EN adds a bounce input for ping-pong scrolling.
module seg_scroll_engine #(
    parameter int          MSG_NIB  = 5,
    parameter int          PAD_NIB  = 1,
    parameter int          DISP_NIB = 4,
    parameter logic [3:0]  PAD_CODE = 4'hC,
    parameter int          TICK_DIV = 33_333_333
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [MSG_NIB*4-1:0]  load_data,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  step,
`ifdef SEG_SCROLL_BOUNCE_EN
    input  logic                  bounce,
`endif
    output logic [DISP_NIB*4-1:0] disp_data,
    output logic                  frame_tick,
    output logic                  wrap
);
    localparam int RING_NIB = MSG_NIB + PAD_NIB;
    localparam int W = RING_NIB * 4;
    localparam int PW = RING_NIB > 1 ? $clog2(RING_NIB) : 1;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] POS_LAST = PW'(RING_NIB - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t        r_state, w_next;
    logic [W-1:0]  r_ring, w_load, w_rot;
    logic [PW-1:0] r_pos, w_pos;
    logic [DW-1:0] r_div;
    logic          r_frame, r_wrap;
    logic          w_accept, w_tick, w_shift, w_dir;

    assign w_accept = load_valid && load_ready;
    assign w_tick   = (r_state == RUN) && (r_div == DIV_LAST);
    assign w_shift  = !w_accept && (w_tick || (r_state == HOLD && step));

`ifdef SEG_SCROLL_BOUNCE_EN
    logic r_bdir, w_turn;
    assign w_dir  = bounce ? r_bdir : dir;
    assign w_turn = bounce && (w_dir ? (w_pos == '0) : (w_pos == PW'(RING_NIB - DISP_NIB)));
    always_ff @(posedge clk or posedge clr)
        if (clr)
            r_bdir <= 1'b0;
        else if (w_accept)
            r_bdir <= dir;
        else if (w_shift && w_turn)
            r_bdir <= ~r_bdir;
`else
    assign w_dir = dir;
`endif

    // Rotation written as shift-or so a single-nibble ring degenerates cleanly.
    assign w_rot = w_dir ? ((r_ring << 4) | (r_ring >> (W - 4)))
                         : ((r_ring >> 4) | (r_ring << (W - 4)));
    assign w_pos = w_dir ? ((r_pos == '0) ? POS_LAST : r_pos - 1'b1)
                         : ((r_pos == POS_LAST) ? '0 : r_pos + 1'b1);

    always_comb begin
        w_load = {RING_NIB{PAD_CODE}};
        w_load[MSG_NIB*4-1:0] = load_data;
    end

    always_ff @(posedge clk or posedge clr)
        if (clr)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = LOAD;
        else if (r_state != IDLE)
            w_next = run ? RUN : HOLD;
    end

    always_comb begin
        load_ready = (r_state != LOAD);
    end

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            r_ring  <= {RING_NIB{PAD_CODE}};
            r_pos   <= '0;
            r_div   <= '0;
            r_frame <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_frame <= w_shift;
            r_wrap  <= w_shift && (w_pos == '0);
            if (w_accept) begin
                r_ring <= w_load;
                r_pos  <= '0;
                r_div  <= '0;
            end else begin
                if (w_shift) begin
                    r_ring <= w_rot;
                    r_pos  <= w_pos;
                end
                if (r_state == RUN)
                    r_div <= w_tick ? '0 : r_div + 1'b1;
            end
        end

    assign disp_data  = r_ring[DISP_NIB*4-1:0];
    assign frame_tick = r_frame;
    assign wrap       = r_wrap;
endmodule

// File: tb/tb_seg_scroll_engine.sv
// tb_seg_scroll_engine: directed checks of load, run/hold/step, direction, collisions and reset.
module tb_seg_scroll_engine;
    logic        clk = 1'b0;
    logic        clr, load_valid, load_ready, run, dir, step, bounce;
    logic [19:0] load_data;
    logic [15:0] disp_data;
    logic        frame_tick, wrap;
    int          n_tests = 0;
    int          n_fail = 0;

    seg_scroll_engine #(
        .MSG_NIB(5), .PAD_NIB(1), .DISP_NIB(4), .PAD_CODE(4'hC), .TICK_DIV(4)
    ) dut (
        .clk(clk), .clr(clr),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .run(run), .dir(dir), .step(step),
`ifdef SEG_SCROLL_BOUNCE_EN
        .bounce(bounce),
`endif
        .disp_data(disp_data), .frame_tick(frame_tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; load_valid = 1'b0; load_data = '0; run = 1'b0; dir = 1'b0; step = 1'b0; bounce = 1'b0;
        #12;
        chk("rst_disp", disp_data, 16'hCCCC);
        chk("rst_ready", load_ready, 1);
        chk("rst_frame", frame_tick, 0);
        chk("rst_wrap", wrap, 0);
        clr = 1'b0; load_valid = 1'b1; load_data = 20'h12345; run = 1'b1;
        cyc(1);
        chk("load_disp", disp_data, 16'h2345);
        chk("load_busy", load_ready, 0);
        load_valid = 1'b0;
        cyc(1);
        chk("load_ready_back", load_ready, 1);
        cyc(3);
        chk("pre_tick_disp", disp_data, 16'h2345);
        chk("pre_tick_frame", frame_tick, 0);
        cyc(1);
        chk("shift1_disp", disp_data, 16'h1234);
        chk("shift1_frame", frame_tick, 1);
        chk("shift1_wrap", wrap, 0);
        cyc(4);
        chk("shift2_disp", disp_data, 16'hC123);
        cyc(16);
        chk("shift6_disp", disp_data, 16'h2345);
        chk("shift6_wrap", wrap, 1);
        // reverse direction
        load_valid = 1'b1; dir = 1'b1;
        cyc(1);
        chk("up_load_disp", disp_data, 16'h2345);
        chk("up_load_frame", frame_tick, 0);
        load_valid = 1'b0;
        cyc(5);
        chk("up_disp", disp_data, 16'h345C);
        chk("up_frame", frame_tick, 1);
        chk("up_wrap", wrap, 0);
        // hold with partially counted divider, then single steps
        dir = 1'b0; load_valid = 1'b1;
        cyc(1);
        load_valid = 1'b0;
        cyc(3);
        run = 1'b0;
        cyc(1);
        chk("hold_noshift", frame_tick, 0);
        step = 1'b1;
        cyc(3);
        chk("step3_disp", disp_data, 16'h5C12);
        chk("step3_frame", frame_tick, 1);
        step = 1'b0; run = 1'b1;
        cyc(1);
        chk("resume_frame", frame_tick, 0);
        chk("resume_disp", disp_data, 16'h5C12);
        cyc(1);
        chk("resume_shift_disp", disp_data, 16'h45C1);
        chk("resume_shift_frame", frame_tick, 1);
        step = 1'b1;
        cyc(1);
        chk("step_in_run", frame_tick, 0);
        step = 1'b0;
        // load on a terminal-count edge
        cyc(2);
        load_valid = 1'b1; load_data = 20'hABCDE;
        cyc(1);
        chk("coll_disp", disp_data, 16'hBCDE);
        chk("coll_frame", frame_tick, 0);
        load_valid = 1'b0;
        cyc(4);
        run = 1'b0;
        cyc(1);
        chk("runoff_tick_disp", disp_data, 16'hABCD);
        chk("runoff_tick_frame", frame_tick, 1);
        run = 1'b1;
        cyc(2);
        #3 clr = 1'b1;
        #1;
        chk("async_clr_disp", disp_data, 16'hCCCC);
        chk("async_clr_ready", load_ready, 1);
        chk("async_clr_frame", frame_tick, 0);
`ifdef SEG_SCROLL_BOUNCE_EN
        begin
            logic [15:0] exp_d[6];
            logic        exp_w[6];
            exp_d = '{16'h1234, 16'hC123, 16'h1234, 16'h2345, 16'h1234, 16'hC123};
            exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            #2 clr = 1'b0;
            bounce = 1'b1; dir = 1'b0; run = 1'b0; load_valid = 1'b1; load_data = 20'h12345;
            cyc(1);
            load_valid = 1'b0;
            cyc(1);
            step = 1'b1;
            for (int i = 0; i < 6; i++) begin
                cyc(1);
                chk($sformatf("bounce_disp%0d", i), disp_data, exp_d[i]);
                chk($sformatf("bounce_wrap%0d", i), wrap, exp_w[i]);
            end
            step = 1'b0;
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
